// File: rtl/led_status_pkg.sv
// rtl/led_status_pkg.sv - shared types and constants for the LED status display
//
// Purpose: state encoding and width/limit constants used by led_status_display
//          and led_pulse_stretcher.
// Ports:   none (package).
package led_status_pkg;

   typedef enum logic [1:0] {
      S_CALIB,
      S_RUNNING,
      S_PASS,
      S_FAIL
   } led_state_t;

   // Legal LED count range; the sweep position register is sized for the maximum.
   localparam int NUM_LEDS_MIN = 4;
   localparam int NUM_LEDS_MAX = 16;
   localparam int POS_W        = $clog2(NUM_LEDS_MAX);

   // Hold counter width; large enough for the largest hold value of 15 ticks.
   localparam int HOLD_W = 4;

endpackage

// File: rtl/led_pulse_stretcher.sv
// rtl/led_pulse_stretcher.sv - stretches a one-cycle pulse over a number of LED ticks
//
// Purpose: a pulse loads the hold counter with HOLD; each tick without a pulse
//          decrements a nonzero counter. A pulse coincident with a tick reloads.
// Ports:
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   clear   in  level; forces the counter to zero (has priority over pulse)
//   tick    in  one-cycle time-base strobe
//   pulse   in  one-cycle event to stretch
//   out     out lit state the counter holds after the current edge
//               (combinational from the next-state value, so the parent can
//               register it into its LED output without an extra cycle of lag)
module led_pulse_stretcher
   import led_status_pkg::*;
#(
   parameter int HOLD = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic tick,
   input  logic pulse,
   output logic out
);

   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;

   always_comb begin
      hold_d = hold_q;
      if (clear) begin
         hold_d = '0;
      end else if (pulse) begin
         hold_d = HOLD_W'(HOLD);
      end else if (tick && (hold_q != '0)) begin
         hold_d = hold_q - HOLD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign out = (hold_d != '0);

endmodule

// File: rtl/led_status_display.sv
// rtl/led_status_display.sv - turns DDR3 test status into visible LED patterns
//
// Purpose: sweep while calibrating; heartbeat / activity / pass count while
//          running; solid on pass; alternating blink on failure.
// Ports:
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   tick       in  one-cycle strobe, sole time base for all patterns
//   calib_done in  level; DDR3 calibration complete
//   activity   in  one-cycle pulse per DDR3 transaction
//   test_done  in  one-cycle pulse per error-free test pass
//   error      in  one-cycle pulse on data miscompare
//   leds       out registered LED drive, 1 = on
//   failed     out registered; high while in S_FAIL
module led_status_display
   import led_status_pkg::*;
#(
   parameter int NUM_LEDS      = 8,
   parameter int ACTIVITY_HOLD = 2,
   parameter int PASS_TARGET   = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                tick,
   input  logic                calib_done,
   input  logic                activity,
   input  logic                test_done,
   input  logic                error,
   output logic [NUM_LEDS-1:0] leds,
   output logic                failed
);

   localparam int                PASS_W   = NUM_LEDS - 2;
   localparam logic [POS_W-1:0]  LAST_POS = POS_W'(NUM_LEDS - 1);
   localparam logic [PASS_W-1:0] TARGET   = PASS_W'(PASS_TARGET);

   if ((NUM_LEDS < NUM_LEDS_MIN) || (NUM_LEDS > NUM_LEDS_MAX)) begin : g_bad_num_leds
      $error("led_status_display: NUM_LEDS out of range");
   end

   led_state_t          state_q,     state_d;
   logic [POS_W-1:0]    sweep_pos_q, sweep_pos_d;
   logic                sweep_up_q,  sweep_up_d;
   logic                heartbeat_q, heartbeat_d;
   logic                blink_q,     blink_d;
   logic [PASS_W-1:0]   pass_cnt_q,  pass_cnt_d;
   logic [NUM_LEDS-1:0] leds_q,      leds_d;
   logic                failed_q,    failed_d;

   logic running;
   logic calibrating;
   logic act_lit;

   assign running     = (state_q == S_RUNNING);
   assign calibrating = (state_q == S_CALIB);

   // Held clear throughout calibration so every entry into running starts dark.
   led_pulse_stretcher #(
      .HOLD (ACTIVITY_HOLD)
   ) u_activity (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (calibrating),
      .tick    (tick & running),
      .pulse   (activity & running),
      .out     (act_lit)
   );

   always_comb begin
      state_d     = state_q;
      sweep_pos_d = sweep_pos_q;
      sweep_up_d  = sweep_up_q;
      heartbeat_d = heartbeat_q;
      blink_d     = blink_q;
      pass_cnt_d  = pass_cnt_q;

      case (state_q)
         S_CALIB: begin
            if (calib_done) begin
               state_d     = S_RUNNING;
               heartbeat_d = 1'b0;
               pass_cnt_d  = '0;
            end else if (tick) begin
               // Bounce between the ends; the direction flips on the tick that leaves an end.
               if (sweep_up_q) begin
                  if (sweep_pos_q == LAST_POS) begin
                     sweep_up_d  = 1'b0;
                     sweep_pos_d = sweep_pos_q - POS_W'(1);
                  end else begin
                     sweep_pos_d = sweep_pos_q + POS_W'(1);
                  end
               end else begin
                  if (sweep_pos_q == '0) begin
                     sweep_up_d  = 1'b1;
                     sweep_pos_d = sweep_pos_q + POS_W'(1);
                  end else begin
                     sweep_pos_d = sweep_pos_q - POS_W'(1);
                  end
               end
            end
         end
         S_RUNNING: begin
            if (error) begin
               state_d = S_FAIL;
               blink_d = 1'b0;
            end else if (!calib_done) begin
               state_d     = S_CALIB;
               sweep_pos_d = '0;
               sweep_up_d  = 1'b1;
               pass_cnt_d  = '0;
            end else begin
               if (tick) begin
                  heartbeat_d = ~heartbeat_q;
               end
               if (test_done) begin
                  pass_cnt_d = pass_cnt_q + PASS_W'(1);
                  if ((PASS_TARGET != 0) && (pass_cnt_d == TARGET)) begin
                     state_d = S_PASS;
                  end
               end
            end
         end
         S_PASS: begin
            if (error) begin
               state_d = S_FAIL;
               blink_d = 1'b0;
            end
         end
         default: begin
            if (tick) begin
               blink_d = ~blink_q;
            end
         end
      endcase
   end

   // LED image is built from next-state values so leds reflect an input one edge after sampling.
   always_comb begin
      leds_d = '0;
      case (state_d)
         S_CALIB: begin
            for (int i = 0; i < NUM_LEDS; i++) begin
               leds_d[i] = (sweep_pos_d == POS_W'(i));
            end
         end
         S_RUNNING: begin
            leds_d = {pass_cnt_d, act_lit, heartbeat_d};
         end
         S_PASS: begin
            leds_d = '1;
         end
         default: begin
            // Even bits lit when blink is low, odd bits when high.
            for (int i = 0; i < NUM_LEDS; i++) begin
               leds_d[i] = ((i % 2) == 0) ^ blink_d;
            end
         end
      endcase
      failed_d = (state_d == S_FAIL);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_CALIB;
         sweep_pos_q <= '0;
         sweep_up_q  <= 1'b1;
         heartbeat_q <= 1'b0;
         blink_q     <= 1'b0;
         pass_cnt_q  <= '0;
         leds_q      <= NUM_LEDS'(1);
         failed_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sweep_pos_q <= sweep_pos_d;
         sweep_up_q  <= sweep_up_d;
         heartbeat_q <= heartbeat_d;
         blink_q     <= blink_d;
         pass_cnt_q  <= pass_cnt_d;
         leds_q      <= leds_d;
         failed_q    <= failed_d;
      end
   end

   assign leds   = leds_q;
   assign failed = failed_q;

endmodule

// File: tb/tb_led_status_display.sv
// tb/tb_led_status_display.sv - scoreboard bench for led_status_display
module tb_led_status_display;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tick;
   logic       calib_done;
   logic       activity;
   logic       test_done;
   logic       error;
   logic [7:0] leds;
   logic       failed;

   always #5 clk = ~clk;

   led_status_display #(
      .NUM_LEDS      (8),
      .ACTIVITY_HOLD (2),
      .PASS_TARGET   (3)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .calib_done (calib_done),
      .activity   (activity),
      .test_done  (test_done),
      .error      (error),
      .leds       (leds),
      .failed     (failed)
   );

   typedef struct {
      string      nm;
      logic [7:0] leds;
      logic       failed;
      int         at_cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic kick  = 1'b0;
   logic [7:0] sweep_exp [9];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every expectation whose cycle has arrived.
   always @(negedge clk or posedge kick) begin
      while ((sb_q.size() != 0) && (sb_q[0].at_cyc <= cyc)) begin
         mon_e = sb_q.pop_front();
         n_cmp++;
         if (leds !== mon_e.leds) begin
            n_bad++;
            $display("FAIL %s leds: got %02h want %02h", mon_e.nm, leds, mon_e.leds);
         end
         n_cmp++;
         if (failed !== mon_e.failed) begin
            n_bad++;
            $display("FAIL %s failed: got %0b want %0b", mon_e.nm, failed, mon_e.failed);
         end
      end
   end

   task automatic exp_next(input string nm, input logic [7:0] l, input logic f);
      exp_t e;
      e.nm = nm; e.leds = l; e.failed = f; e.at_cyc = cyc + 1;
      sb_q.push_back(e);
   endtask

   task automatic exp_now(input string nm, input logic [7:0] l, input logic f);
      exp_t e;
      e.nm = nm; e.leds = l; e.failed = f; e.at_cyc = cyc;
      sb_q.push_back(e);
      kick = 1'b1;
      #1 kick = 1'b0;
   endtask

   task automatic step(input logic t, input logic a, input logic d, input logic e);
      tick = t; activity = a; test_done = d; error = e;
      @(negedge clk);
      tick = 1'b0; activity = 1'b0; test_done = 1'b0; error = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_step(input string nm, input logic [7:0] l, input logic f,
                           input logic t, input logic a, input logic d, input logic e);
      exp_next(nm, l, f);
      step(t, a, d, e);
   endtask

   task automatic do_tick(input string nm, input logic [7:0] l, input logic f);
      chk_step(nm, l, f, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      chk_step("reset", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      idle(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

   initial begin
      int waited;
      sweep_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};
      reset_n = 1'b0; tick = 1'b0; calib_done = 1'b0;
      activity = 1'b0; test_done = 1'b0; error = 1'b0;
      @(negedge clk);
      chk_step("rst_leds", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      chk_step("rst_idle", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Sweep with bounce at bit 7
      for (int i = 0; i < 9; i++) begin
         do_tick($sformatf("sweep%0d", i), sweep_exp[i], 1'b0);
      end
      chk_step("calib_err_ignored", 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // calib_done beats a coincident tick; heartbeat afterwards
      calib_done = 1'b1;
      chk_step("calib_vs_tick", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      do_tick("hb_1", 8'h01, 1'b0);
      do_tick("hb_0", 8'h00, 1'b0);
      do_tick("hb_1b", 8'h01, 1'b0);

      // Activity stretch and reload on a coincident tick
      chk_step("act_load", 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      do_tick("act_t1", 8'h02, 1'b0);
      do_tick("act_t2", 8'h01, 1'b0);
      chk_step("act_reload", 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(3);
      do_tick("reload_t1", 8'h03, 1'b0);
      do_tick("reload_t2", 8'h00, 1'b0);

      // Pass count to target, ignored inputs in pass, then failure blink
      chk_step("pass1", 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_step("pass2", 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_step("pass3", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      calib_done = 1'b0;
      chk_step("pass_ignore", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk_step("err_in_pass", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      do_tick("blink_a", 8'hAA, 1'b1);
      do_tick("blink_b", 8'h55, 1'b1);

      // error beats test_done/activity; fail is sticky through calib_done drop
      do_reset();
      calib_done = 1'b1;
      chk_step("run5", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_step("p5_pass1", 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      do_tick("p5_hb", 8'h05, 1'b0);
      chk_step("err_vs_done", 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      calib_done = 1'b0;
      chk_step("fail_sticky", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_tick("fail_blink", 8'hAA, 1'b1);

      // calib_done drop restarts sweep and clears pass count; async reset
      do_reset();
      calib_done = 1'b1;
      chk_step("run6", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_step("p6_1", 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_step("p6_2", 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      calib_done = 1'b0;
      chk_step("calib_drop", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      do_tick("resweep1", 8'h02, 1'b0);
      do_tick("resweep2", 8'h04, 1'b0);
      calib_done = 1'b1;
      chk_step("pass_cleared", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      calib_done = 1'b0;
      chk_step("drop2", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_tick("sw_a", 8'h02, 1'b0);
      do_tick("sw_b", 8'h04, 1'b0);
      #2 reset_n = 1'b0;
      #1 exp_now("async_rst", 8'h01, 1'b0);
      @(negedge clk);
      chk_step("rst_held", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      idle(1);
      do_tick("post_rst", 8'h02, 1'b0);

      waited = 0;
      while ((sb_q.size() != 0) && (waited < 20)) begin
         @(negedge clk);
         waited++;
      end
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d pending, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
